// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit a+b+cin split into STAGES chunks, one register per chunk.
// Optional signed-overflow output enabled by defining RCA_PIPE_OVF_EN.

module rca_pipe_stage #(
    parameter int WIDTH = 16,
    parameter int CW    = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf_o
`endif
);
    logic [CW:0]      c;
    logic [CW-1:0]    s;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q;

    // Per-bit full adders over chunk K; lower sum bits pass through untouched.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carry_i;
        for (int i = 0; i < CW; i++) begin
            s[i]   = a_i[K*CW+i] ^ b_i[K*CW+i] ^ c[i];
            c[i+1] = (a_i[K*CW+i] & b_i[K*CW+i]) | (c[i] & (a_i[K*CW+i] ^ b_i[K*CW+i]));
        end
        sum_d             = sum_i;
        sum_d[K*CW +: CW] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (load_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= sum_d;
            carry_q <= c[CW];
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

`ifdef RCA_PIPE_OVF_EN
    logic ovf_q;

    // Only meaningful in the top chunk: carry into MSB xor carry out of MSB.
    always_ff @(posedge clk) begin
        if (rst)         ovf_q <= 1'b0;
        else if (load_i) ovf_q <= c[CW] ^ c[CW-1];
    end

    assign ovf_o = ovf_q;
`endif
endmodule

module rca_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = WIDTH / STAGES;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("rca_pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
        end
    endgenerate

    logic [STAGES-1:0]             vld_q, vld_d, adv, load;
    logic [STAGES:0][WIDTH-1:0]    a_p, b_p, s_p;
    logic [STAGES:0]               c_p;

    assign a_p[0] = a;
    assign b_p[0] = b;
    assign s_p[0] = '0;
    assign c_p[0] = cin;

    // Advance ripples back from the consumer so a full pipe still accepts while draining.
    always_comb begin
        adv           = '0;
        adv[STAGES-1] = vld_q[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
        end
    end

    assign in_ready = ~vld_q[0] | adv[0];

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
        vld_d = (vld_q & ~adv) | load;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

`ifdef RCA_PIPE_OVF_EN
    logic [STAGES:1] ovf_p;
`endif

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            rca_pipe_stage #(
                .WIDTH (WIDTH),
                .CW    (CW),
                .K     (k)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load_i  (load[k]),
                .a_i     (a_p[k]),
                .b_i     (b_p[k]),
                .sum_i   (s_p[k]),
                .carry_i (c_p[k]),
                .a_o     (a_p[k+1]),
                .b_o     (b_p[k+1]),
                .sum_o   (s_p[k+1]),
                .carry_o (c_p[k+1])
`ifdef RCA_PIPE_OVF_EN
                ,
                .ovf_o   (ovf_p[k+1])
`endif
            );
        end
    endgenerate

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_p[STAGES];
    assign cout      = c_p[STAGES];

    // Operands leaving the last stage and lower-stage overflow flags have no consumer.
    logic unused_tail;
`ifdef RCA_PIPE_OVF_EN
    assign ovf         = ovf_p[STAGES];
    assign unused_tail = ^{a_p[STAGES], b_p[STAGES], ovf_p};
`else
    assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};
`endif
endmodule

// File: doc/rca_pipe_adder.md
Name: rca_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add (a + b + cin) into STAGES ripple-carry chunks with one register stage per chunk.
- Sits between producer and consumer on valid/ready streams. Sustains one add per clock with full backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; range 1..WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/cin valid this cycle.
- in_ready  output  1  adder accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits cleared; sum=0, cout=0, out_valid=0.
  - Reset is synchronous; any in-flight operations are discarded. No output pulse occurs during or after reset.
  - in_ready is combinational and equals 1 while the pipe is empty, including in the cycle after reset.
- Stage k (0..STAGES-1):
  - Registers sum bits [k*CW +: CW] = A_chunk + B_chunk + carry_in_k, and the carry out of that chunk.
  - carry_in_0 = cin. carry_in_k = the registered carry of stage k-1.
  - The unprocessed upper chunks of a and b travel with the token. Already-computed lower sum bits also travel with the token.
- Arithmetic: each chunk is a pure ripple carry (per-bit full adder). No carry lookahead across chunks. cout = carry out of stage STAGES-1.
- Handshake:
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - Stage k advances when it holds a token and stage k+1 is empty or advancing. The last stage advances when out_ready=1.
  - in_ready = !valid[0] || advance[0]. This is combinational from out_ready through the chain; no bubble is inserted.
- Latency: exactly STAGES clocks from accepted input to out_valid, given out_ready=1 throughout.
- Throughput: 1 result per clock when out_valid && out_ready continuously.
- Stall: while out_valid=1 and out_ready=0, sum/cout/out_valid are held stable and upstream stages fill. in_ready drops only when all STAGES registers hold tokens.
- Simultaneous in-accept and out-accept on a full pipe: both happen; occupancy stays unchanged.
- Ordering: results emerge strictly in acceptance order. No reordering and no drops.
- Wrap-around:
  - all-ones + all-ones + 1 gives sum=all-ones, cout=1.
  - all-ones + 0 + 1 gives sum=0, cout=1.
- STAGES=1 degenerates to a registered full-width RCA with a 1-cycle latency.
- Out-of-range parameters (WIDTH % STAGES != 0): elaboration-time error via generate check.

Optional Feature:
- Macro RCA_PIPE_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB. It is registered alongside sum.
  - ovf resets to 0 and is held under stall like sum.
- When undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: apply a=0x00FF, b=0x0001, cin=0 -> out_valid rises exactly 4 clocks after accept, sum=0x0100, cout=0.
- Cross-chunk carry: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. A second case a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Streaming: 8 back-to-back random pairs, in_valid=1 each cycle -> 8 consecutive out_valid cycles in order, each matching the reference model a+b+cin.
- Backpressure: hold out_ready=0 while streaming -> in_ready drops after 4 accepts and sum stays stable. On release, results appear in order with no loss or duplication.
- Reset mid-operation: load 3 tokens, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0 on the next edge, no stale token ever emerges, and in_ready=1.
- With RCA_PIPE_OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1. A second case a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
